// File: rtl/msg_generator.sv
// msg_generator
//   Test-message source for the AES adder/remover path. Each accepted start
//   emits msg_words 32-bit words on an Avalon-ST source interface with
//   sop/eop framing and ready/valid backpressure. Word format:
//   {msg_id[7:0], PATTERN[15:0], idx[7:0]}. msg_id advances once per
//   completed non-empty message.
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous reset, active-high
//   msg_words      word count, sampled only on an accepted start
//   msg_start      single-cycle start pulse
//   st_data        stream data
//   st_valid       stream valid
//   st_ready       sink ready
//   st_sop         first word of message
//   st_eop         last word of message
//   busy           high while sending
//   words_sent     words accepted by sink for current/last message
//   msg_done       one-cycle pulse on message completion
//   start_dropped  one-cycle pulse when a start is ignored
module msg_generator #(
  parameter int unsigned     DATA_W  = 32,
  parameter int unsigned     WORDS_W = 8,
  parameter logic [15:0]     PATTERN = 16'hA5C3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WORDS_W-1:0] msg_words,
  input  logic               msg_start,
  output logic [DATA_W-1:0]  st_data,
  output logic               st_valid,
  input  logic               st_ready,
  output logic               st_sop,
  output logic               st_eop,
  output logic               busy,
  output logic [WORDS_W-1:0] words_sent,
  output logic               msg_done,
  output logic               start_dropped
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t             state;
  logic [7:0]         msg_id;
  logic [WORDS_W-1:0] idx;
  logic [WORDS_W-1:0] n_lat;

  logic [WORDS_W-1:0] idx_nxt;
  logic               last_nxt;

  // Framing for the word that follows the current one is precomputed so
  // st_sop/st_eop/st_data can be registered alongside the index update.
  always_comb begin
    idx_nxt  = idx + WORDS_W'(1);
    last_nxt = (idx_nxt == (n_lat - WORDS_W'(1)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      msg_id        <= '0;
      idx           <= '0;
      n_lat         <= '0;
      st_data       <= '0;
      st_valid      <= 1'b0;
      st_sop        <= 1'b0;
      st_eop        <= 1'b0;
      busy          <= 1'b0;
      words_sent    <= '0;
      msg_done      <= 1'b0;
      start_dropped <= 1'b0;
    end else begin
      msg_done      <= 1'b0;
      start_dropped <= 1'b0;
      unique case (state)
        IDLE: begin
          if (msg_start) begin
            words_sent <= '0;
            if (msg_words != '0) begin
              n_lat    <= msg_words;
              idx      <= '0;
              state    <= SEND;
              st_valid <= 1'b1;
              busy     <= 1'b1;
              st_data  <= {msg_id, PATTERN, 8'(0)};
              st_sop   <= 1'b1;
              st_eop   <= (msg_words == WORDS_W'(1));
            end else begin
              // Empty message: completion pulse only, msg_id untouched.
              msg_done <= 1'b1;
            end
          end
        end
        SEND: begin
          if (msg_start) begin
            start_dropped <= 1'b1;
          end
          if (st_ready) begin
            words_sent <= words_sent + WORDS_W'(1);
            if (st_eop) begin
              state    <= IDLE;
              st_valid <= 1'b0;
              busy     <= 1'b0;
              st_sop   <= 1'b0;
              st_eop   <= 1'b0;
              st_data  <= '0;
              idx      <= '0;
              msg_done <= 1'b1;
              msg_id   <= msg_id + 8'd1;
            end else begin
              idx     <= idx_nxt;
              st_data <= {msg_id, PATTERN, 8'(idx_nxt)};
              st_sop  <= 1'b0;
              st_eop  <= last_nxt;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
